mul_seq_ctrl: RTL
=================

// Module: mul_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the EX-stage MUL operation (ALU op 3'b101).
//  Accepts a MUL request from the EX stage and holds operands in local registers.
//  Iterates a shift-add datapath, stalling the pipeline until the 32-bit product is ready.
//  Sits beside the single-cycle ALU; the EX result mux selects data_o when valid_o=1.
// PARAMETERS
//  BITS_PER_CYCLE  1   multiplier bits retired per iteration; legal values 1,2,4; N = 32/BITS_PER_CYCLE
//  EARLY_EXIT      0   1: finish as soon as remaining multiplier bits are all zero
// PORTS
//  clk_i        in   1   clock; all state updates on rising edge
//  rst_i        in   1   synchronous reset, active-high
//  valid_i      in   1   EX stage holds a valid instruction
//  ALUCtrl_i    in   3   ALU op of that instruction; MUL = 3'b101
//  data1_i      in   32  multiplicand (signed)
//  data2_i      in   32  multiplier (signed)
//  flush_i      in   1   EX instruction squashed (branch / exception)
//  stall_o      out  1   hold IF/ID/EX registers and the PC this cycle
//  busy_o       out  1   FSM not in IDLE
//  valid_o      out  1   data_o holds the final product; 1-cycle pulse
//  data_o       out  32  low 32 bits of data1_i*data2_i
// BEHAVIOUR
//  Reset:
//   - FSM=IDLE; stall_o=0, busy_o=0, valid_o=0, data_o=0, internal acc/mcand/mplier/count=0.
//  start = valid_i & (ALUCtrl_i==3'b101) & ~flush_i & (state==IDLE).
//  IDLE:
//   - stall_o = start (combinational); other ops pass through with stall_o=0.
//   - On start: mcand<=data1_i, mplier<=data2_i, acc<=0, count<=0; go to RUN.
//  RUN, each cycle:
//   - acc += mcand * mplier[B-1:0]; mcand <<= B; mplier >>= B (logical); count++.
//   - All math is mod 2^32. The low 32 bits are identical for signed and unsigned, so no sign fix-up.
//   - stall_o=1.
//   - Go to DONE after the N-th iteration.
//   - EARLY_EXIT=1: also go to DONE after any iteration that leaves mplier==0.
//   - If data2_i==0, that happens after iteration 1.
//  DONE, one cycle:
//   - valid_o=1, data_o=acc, stall_o=0 (the pipeline advances the MUL this edge); next state IDLE.
//   - valid_i/ALUCtrl_i are ignored in DONE; they still show the completing MUL.
//   - data_o holds its value until the next DONE; valid_o=0 outside DONE.
//  Latency (EARLY_EXIT=0): start accepted in cycle T, valid_o in cycle T+N+1; stall_o high in T..T+N.
//   - B=1: 33 stall cycles.
//  Back-to-back MULs: the second is accepted in the cycle after DONE (IDLE). No bubble beyond that.
//  flush_i:
//   - In RUN or DONE: next state IDLE, no valid_o pulse afterwards, data_o unchanged.
//   - In the flush cycle itself: stall_o=0, valid_o=0.
//  rst_i mid-operation: same as reset (everything cleared, data_o=0); rst_i has priority over flush_i and start.
//  Simultaneous start and flush_i in IDLE: no start.
// STRUCTURE
//  Shared header alu_defs.vh holds the ALU op `defines (AND..SRAI, MUL=3'b101).
//  Both ALU and this block include it; the op encoding is never re-declared locally.
//  FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) lives local to this module.
//  One sub-module, mul_step_dp: combinational single iteration.
//   - Inputs acc, mcand, mplier; outputs next values.
//   - Parameterised by BITS_PER_CYCLE.
//  The FSM, counter and operand registers stay in mul_seq_ctrl.
// TESTING
//  1. B=1: start with 7 x -3.
//     -> stall_o high for 33 cycles; valid_o in cycle T+33; data_o=32'hFFFFFFEB.
//  2. 32'h80000000 x -1 -> data_o=32'h80000000 (wrap); 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'h00000001.
//  3. Back-to-back MUL (5x6 then 9x9).
//     -> valid_o pulses with 30 then 81; the second start is accepted exactly 1 cycle after the first DONE.
//  4. flush_i asserted on RUN iteration 10.
//     -> IDLE next cycle; no valid_o; stall_o=0 in the flush cycle; data_o keeps its previous value.
//  5. rst_i on RUN iteration 5, and non-MUL ops (ADD, SUB) presented in IDLE.
//     -> all outputs 0 after the reset edge; no stall for non-MUL ops.
//  6. BITS_PER_CYCLE=4, EARLY_EXIT=1, 1234 x 3.
//     -> valid_o at T+2, data_o=3702.
//     With data2_i=0 -> valid_o at T+2 with 0.

Source files
------------

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage sequential multiplier: ALU op encoding
// used to recognise a MUL, datapath width and iteration-count helper.
package mul_seq_ctrl_pkg;

  localparam int XLEN = 32;

  // ALU op that selects the multi-cycle multiplier
  localparam logic [2:0] ALU_MUL = 3'b101;

  function automatic int mul_iters(input int bits_per_cycle);
    return XLEN / bits_per_cycle;
  endfunction

endpackage

// File: rtl/mul_step_dp.sv
// One shift-add iteration: folds the low BITS_PER_CYCLE multiplier bits into
// the accumulator and shifts the operands ready for the next iteration.
module mul_step_dp
  import mul_seq_ctrl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [31:0] acc,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic [31:0] acc_next,
  output logic [31:0] mcand_next,
  output logic [31:0] mplier_next
);

  logic [31:0] pp   [BITS_PER_CYCLE];
  logic [31:0] psum [BITS_PER_CYCLE+1];

  assign psum[0] = acc;

  // Partial products chained through an adder per retired multiplier bit
  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp[gi]     = mplier[gi] ? (mcand << gi) : 32'd0;
      assign psum[gi+1] = psum[gi] + pp[gi];
    end
  endgenerate

  assign acc_next    = psum[BITS_PER_CYCLE];
  assign mcand_next  = mcand << BITS_PER_CYCLE;
  assign mplier_next = mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MUL sequencer beside the single-cycle ALU; stalls the pipeline
// while the shift-add datapath iterates and pulses valid_o with the product.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter bit EARLY_EXIT     = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [2:0]  ALUCtrl_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] data_o
);

  localparam int         N    = mul_iters(BITS_PER_CYCLE);
  localparam logic [5:0] LAST = 6'(N - 1);

  generate
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
      $error("BITS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_reg;
  logic [31:0] acc_reg;
  logic [31:0] mcand_reg;
  logic [31:0] mplier_reg;
  logic [31:0] data_reg;
  logic [5:0]  count_reg;

  logic [31:0] acc_next;
  logic [31:0] mcand_next;
  logic [31:0] mplier_next;
  logic        start;
  logic        finish;

  mul_step_dp #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc        (acc_reg),
    .mcand      (mcand_reg),
    .mplier     (mplier_reg),
    .acc_next   (acc_next),
    .mcand_next (mcand_next),
    .mplier_next(mplier_next)
  );

  assign start  = valid_i & (ALUCtrl_i == ALU_MUL) & ~flush_i & (state_reg == ST_IDLE);
  assign finish = (count_reg == LAST) | (EARLY_EXIT & (mplier_next == 32'd0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mcand_reg  <= data1_i;
            mplier_reg <= data2_i;
            acc_reg    <= '0;
            count_reg  <= '0;
            state_reg  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            state_reg <= ST_IDLE;
          end else begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            count_reg  <= count_reg + 6'd1;
            if (finish) state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          // A squashed MUL must not disturb the last delivered product
          if (!flush_i) data_reg <= acc_reg;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_reg != ST_IDLE);
  assign stall_o = start | ((state_reg == ST_RUN) & ~flush_i);
  assign valid_o = (state_reg == ST_DONE) & ~flush_i;
  // The product is visible in the DONE cycle itself, then held in data_reg
  assign data_o  = valid_o ? acc_reg : data_reg;

endmodule
